// File: rtl/vga_frame_scanout.sv
`timescale 1ns/1ps
// vga_frame_scanout: 320x240x3 framebuffer written through (x, y, color, plot), scanned out
// as 640x480@60 VGA with every stored pixel shown as a 2x2 block.
// Ports:
//   clk_50      in  50 MHz system clock
//   rst         in  synchronous reset, active-low
//   x, y        in  write column / row (10 bits each); out-of-range writes are dropped
//   color       in  {R,G,B} write data
//   plot        in  write strobe, sampled every clk_50 edge
//   fb_ready    out high once the post-reset clear has finished
//   VGA_R/G/B   out 10-bit channels, all ones or all zeros
//   VGA_HS/VS   out active-low syncs
//   VGA_BLANK   out high in the visible area only
//   VGA_SYNC    out tied low
//   VGA_CLK     out 25 MHz pixel clock (registered clk_50/2)
module vga_frame_scanout #(
    parameter int         FB_W     = 320,
    parameter int         FB_H     = 240,
    parameter int         H_VIS    = 640,
    parameter int         H_FP     = 16,
    parameter int         H_SYNC   = 96,
    parameter int         H_BP     = 48,
    parameter int         V_VIS    = 480,
    parameter int         V_FP     = 10,
    parameter int         V_SYNC   = 2,
    parameter int         V_BP     = 33,
    parameter logic [2:0] BG_COLOR = 3'b000
) (
    input  logic       clk_50,
    input  logic       rst,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [2:0] color,
    input  logic       plot,
    output logic       fb_ready,
    output logic [9:0] VGA_R,
    output logic [9:0] VGA_G,
    output logic [9:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK,
    output logic       VGA_SYNC,
    output logic       VGA_CLK
);

    localparam int NPIX = FB_W * FB_H;
    localparam int AW   = $clog2(NPIX);

    localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS_C = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C = 10'(V_VIS);
    localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [9:0] FB_W_C = 10'(FB_W);
    localparam logic [9:0] FB_H_C = 10'(FB_H);

    localparam logic [AW-1:0] CLR_LAST = AW'(NPIX - 1);
    localparam logic [AW-1:0] FB_W_A   = AW'(FB_W);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic          fb_ready_q, fb_ready_d;
    logic          clr_we;

    always_ff @(posedge clk_50) begin
        if (!rst) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
            fb_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            fb_ready_q <= fb_ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        fb_ready_d = fb_ready_q;
        clr_we     = 1'b0;
        unique case (state_q)
            S_CLEAR: begin
                clr_we     = 1'b1;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == CLR_LAST) begin
                    state_d    = S_RUN;
                    fb_ready_d = 1'b1;
                end
            end
            S_RUN: begin
            end
        endcase
    end

    // Write port is shared by the clear sweep and the game's plot strobe;
    // plots are simply dropped while the clear owns the port.
    logic          wr_hit;
    logic [AW-1:0] wr_addr;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_din;

    always_comb begin
        wr_hit   = (state_q == S_RUN) && plot && (x < FB_W_C) && (y < FB_H_C);
        wr_addr  = AW'(y) * FB_W_A + AW'(x);
        mem_we   = clr_we | wr_hit;
        mem_addr = clr_we ? clr_addr_q : wr_addr;
        mem_din  = clr_we ? BG_COLOR : color;
    end

    // Scan counters advance on the clk_50 edges where pix_en is high,
    // i.e. once per 25 MHz pixel clock.
    logic       pix_en_q;
    logic [9:0] h_cnt_q, v_cnt_q;

    always_ff @(posedge clk_50) begin
        if (!rst) begin
            pix_en_q <= 1'b0;
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
        end else begin
            pix_en_q <= ~pix_en_q;
            if (pix_en_q) begin
                if (h_cnt_q == H_LAST) begin
                    h_cnt_q <= '0;
                    v_cnt_q <= (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
                end else begin
                    h_cnt_q <= h_cnt_q + 10'd1;
                end
            end
        end
    end

    // Stage 1: read address plus the timing flags that travel alongside it.
    logic          vis_d, hs_d, vs_d;
    logic [AW-1:0] rd_addr_d;
    logic          vis1_q, hs1_q, vs1_q;
    logic [AW-1:0] rd_addr_q;

    always_comb begin
        vis_d     = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
        hs_d      = !((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
        vs_d      = !((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
        rd_addr_d = '0;
        if (vis_d) begin
            rd_addr_d = AW'(v_cnt_q[9:1]) * FB_W_A + AW'(h_cnt_q[9:1]);
        end
    end

    always_ff @(posedge clk_50) begin
        if (!rst) begin
            vis1_q    <= 1'b0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            rd_addr_q <= '0;
        end else if (pix_en_q) begin
            vis1_q    <= vis_d;
            hs1_q     <= hs_d;
            vs1_q     <= vs_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    // Framebuffer: one write port, one synchronous read port.
    // A same-edge read of the written address returns the old value.
    logic [2:0] mem [NPIX];
    logic [2:0] rd_q;

    always_ff @(posedge clk_50) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_din;
        end
        rd_q <= mem[rd_addr_q];
    end

    // Stage 2: registered outputs, two pixel clocks behind the counters.
    logic [2:0] rgb_q;
    logic       hs_q, vs_q, blank_q;

    always_ff @(posedge clk_50) begin
        if (!rst) begin
            rgb_q   <= 3'b000;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
        end else if (pix_en_q) begin
            rgb_q   <= vis1_q ? rd_q : 3'b000;
            hs_q    <= hs1_q;
            vs_q    <= vs1_q;
            blank_q <= vis1_q;
        end
    end

    assign VGA_R     = {10{rgb_q[2]}};
    assign VGA_G     = {10{rgb_q[1]}};
    assign VGA_B     = {10{rgb_q[0]}};
    assign VGA_HS    = hs_q;
    assign VGA_VS    = vs_q;
    assign VGA_BLANK = blank_q;
    assign VGA_SYNC  = 1'b0;
    assign VGA_CLK   = pix_en_q;
    assign fb_ready  = fb_ready_q;

endmodule

// File: tb/tb_vga_frame_scanout.sv
`timescale 1ns/1ps
// Bench for vga_frame_scanout, built with a reduced framebuffer and raster
// so whole frames fit in a short run.
module tb_vga_frame_scanout;

    localparam int FB_W = 8, FB_H = 6;
    localparam int H_VIS = 16, H_FP = 2, H_SYNC = 4, H_BP = 2;
    localparam int V_VIS = 12, V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FTOT = H_TOT * V_TOT;
    localparam int NPIX = FB_W * FB_H;

    logic       clk_50 = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] x = '0, y = '0;
    logic [2:0] color = '0;
    logic       plot = 1'b0;
    logic       fb_ready;
    logic [9:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_CLK;

    vga_frame_scanout #(
        .FB_W(FB_W), .FB_H(FB_H),
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .BG_COLOR(3'b000)
    ) dut (
        .clk_50(clk_50), .rst(rst),
        .x(x), .y(y), .color(color), .plot(plot),
        .fb_ready(fb_ready),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK(VGA_BLANK), .VGA_SYNC(VGA_SYNC), .VGA_CLK(VGA_CLK)
    );

    always #10 clk_50 = ~clk_50;

    int tests = 0;
    int fails = 0;
    int k = 0;
    bit mon_on = 1'b0;
    int mod_k = NPIX;
    int cap_frame = -1;
    logic [2:0]  mdl [FB_H][FB_W];
    logic [29:0] scr [V_VIS][H_VIS];

    function automatic logic [29:0] expand(logic [2:0] c);
        return {{10{c[2]}}, {10{c[1]}}, {10{c[0]}}};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
        end
    endtask

    // k = clk_50 edges since the last edge that sampled rst low.
    always @(posedge clk_50) begin
        if (!rst) k <= 0;
        else k <= k + 1;
    end

    // Reference raster: outputs seen after edge k show pixel (k-4)/2 of
    // the 800x525-style sequence; earlier edges show reset values.
    always @(negedge clk_50) begin : mon
        int p, f, q, h, v;
        bit vis;
        if (mon_on) begin
            chk("vga_sync", 32'(VGA_SYNC), 0);
            chk("vga_clk", 32'(VGA_CLK), k % 2);
            chk("fb_ready", 32'(fb_ready), 32'(k >= NPIX));
            if (k < 4) begin
                chk("rst_hs", 32'(VGA_HS), 1);
                chk("rst_vs", 32'(VGA_VS), 1);
                chk("rst_blank", 32'(VGA_BLANK), 0);
                chk("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 0);
            end else begin
                p = (k - 4) / 2;
                f = p / FTOT;
                q = p % FTOT;
                h = q % H_TOT;
                v = q / H_TOT;
                vis = (h < H_VIS) && (v < V_VIS);
                chk("hs", 32'(VGA_HS),
                    32'(!(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC)));
                chk("vs", 32'(VGA_VS),
                    32'(!(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC)));
                chk("blank", 32'(VGA_BLANK), 32'(vis));
                if (!vis) begin
                    chk("rgb_off", 32'({VGA_R, VGA_G, VGA_B}), 0);
                end else if (f > (mod_k / 2) / FTOT) begin
                    chk("rgb", 32'({VGA_R, VGA_G, VGA_B}),
                        32'(expand(mdl[v / 2][h / 2])));
                    scr[v][h] = {VGA_R, VGA_G, VGA_B};
                    if (h == H_VIS - 1 && v == V_VIS - 1) cap_frame = f;
                end
            end
        end
    end

    task automatic do_reset(int ncyc);
        @(negedge clk_50);
        rst = 1'b0;
        plot = 1'b0;
        @(posedge clk_50);
        for (int r = 0; r < FB_H; r++)
            for (int c = 0; c < FB_W; c++) mdl[r][c] = 3'b000;
        mod_k = NPIX;
        cap_frame = -1;
        mon_on = 1'b1;
        repeat (ncyc - 1) @(posedge clk_50);
        @(negedge clk_50);
        rst = 1'b1;
    endtask

    // Waits for fb_ready; optionally pulses a plot at (5,5) mid-clear.
    task automatic ready_latency(bit plot_mid);
        int n = 0;
        while (fb_ready !== 1'b1 && n < NPIX + 20) begin
            plot = plot_mid && (n == 5);
            x = 10'd5;
            y = 10'd5;
            color = 3'd7;
            @(negedge clk_50);
            n++;
        end
        plot = 1'b0;
        chk("ready_latency", n, NPIX);
    endtask

    task automatic wr(int xi, int yi, logic [2:0] c);
        @(negedge clk_50);
        x = 10'(xi);
        y = 10'(yi);
        color = c;
        plot = 1'b1;
        if (k >= NPIX && xi < FB_W && yi < FB_H) begin
            mdl[yi][xi] = c;
            mod_k = k + 1;
        end
    endtask

    task automatic idle();
        @(negedge clk_50);
        plot = 1'b0;
    endtask

    task automatic wait_frame();
        int tgt = (mod_k / 2) / FTOT + 1;
        int n = 0;
        while (cap_frame < tgt && n < 6 * FTOT) begin
            @(negedge clk_50);
            n++;
        end
        chk("frame_wait", 32'(cap_frame >= tgt), 1);
    endtask

    typedef struct {
        int          x;
        int          y;
        logic [2:0]  c;
        int          sh;
        int          sv;
        logic [29:0] exp;
    } vec_t;

    vec_t tv[7];

    initial begin
        tv[0] = '{0, 0, 3'b100, 1, 1, 30'h3FF00000};
        tv[1] = '{7, 5, 3'b011, 14, 10, 30'h000FFFFF};
        tv[2] = '{8, 0, 3'b111, 2, 0, 30'h00000000};
        tv[3] = '{0, 6, 3'b111, 15, 11, 30'h000FFFFF};
        tv[4] = '{3, 2, 3'b010, 6, 4, 30'h000FFC00};
        tv[5] = '{1023, 1023, 3'b101, 7, 5, 30'h000FFC00};
        tv[6] = '{0, 0, 3'b100, 0, 0, 30'h3FF00000};

        // Reset, clear latency, plot dropped during clear.
        do_reset(3);
        ready_latency(1'b1);
        wait_frame();
        chk("clear_plot", 32'(scr[10][10]), 0);
        chk("clear_plot2", 32'(scr[11][11]), 0);

        // Directed writes, including out-of-range ones.
        for (int i = 0; i < 7; i++) wr(tv[i].x, tv[i].y, tv[i].c);
        idle();
        wait_frame();
        for (int i = 0; i < 7; i++)
            chk($sformatf("vec%0d", i), 32'(scr[tv[i].sv][tv[i].sh]), 32'(tv[i].exp));

        // Full back-to-back sweep with color (x+y)%8.
        for (int yy = 0; yy < FB_H; yy++)
            for (int xx = 0; xx < FB_W; xx++)
                wr(xx, yy, 3'((xx + yy) % 8));
        idle();
        wait_frame();
        for (int v = 0; v < V_VIS; v++)
            for (int h = 0; h < H_VIS; h++)
                chk("sweep", 32'(scr[v][h]), 32'(expand(3'((h / 2 + v / 2) % 8))));

        // Random writes with some out-of-range coordinates and idle gaps.
        repeat (400) begin
            if ($urandom_range(0, 3) != 0)
                wr($urandom_range(0, FB_W + 1), $urandom_range(0, FB_H + 1),
                   3'($urandom_range(0, 7)));
            else
                idle();
        end
        idle();
        wait_frame();

        // One-cycle reset mid-frame during RUN.
        repeat (300 + $urandom_range(0, 200)) @(negedge clk_50);
        do_reset(1);
        ready_latency(1'b0);
        wait_frame();
        for (int v = 0; v < V_VIS; v++)
            for (int h = 0; h < H_VIS; h++)
                chk("post_reset_bg", 32'(scr[v][h]), 0);

        // Reset in the middle of the clear restarts it from address 0.
        wr(2, 2, 3'b111);
        idle();
        do_reset(1);
        repeat (20) @(negedge clk_50);
        do_reset(1);
        ready_latency(1'b0);
        wait_frame();
        chk("reclear", 32'(scr[4][4]), 0);

        repeat (2 * FTOT) @(negedge clk_50);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
